// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 write-only register file: frames of R/W, 7-bit address, DATA_W data, MSB first.
// Optional readback of a register on cipo when SPI_REGFILE_READBACK_EN is defined.
module spi_regfile_peripheral #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int         FL     = 8 + DATA_W;
    localparam int         CW     = $clog2(FL + 2);
    localparam logic [7:0] NREGS8 = 8'(NUM_REGS);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK, ST_COMMIT} state_t;

    logic                       r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic                       r_copi_s1, r_copi_s2;
    logic                       r_ncs_s1, r_ncs_s2;
    logic [CW-1:0]              r_cnt;
    logic [FL-1:0]              r_buf;
    logic                       r_armed;
    state_t                     r_state;
    logic [NUM_REGS*DATA_W-1:0] r_regs;
    logic [NUM_REGS-1:0]        r_wr_strobe;
    logic                       r_frame_err;
    logic                       r_ok;
    logic                       r_pend;
    logic [6:0]                 r_wa;
    logic [DATA_W-1:0]          r_wd;

    logic                       w_sclk_rise, w_ncs_fall, w_ncs_rise, w_sample;
    logic                       w_rw, w_len_ok, w_addr_ok, w_accept, w_bad;
    logic [6:0]                 w_addr;
    logic [DATA_W-1:0]          w_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_copi_s1 <= 1'b0;
            r_copi_s2 <= 1'b0;
            r_ncs_s1  <= 1'b0;
            r_ncs_s2  <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_copi_s1 <= copi;
            r_copi_s2 <= r_copi_s1;
            r_ncs_s1  <= ncs;
            r_ncs_s2  <= r_ncs_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_ncs_fall  = r_ncs_s2 & ~r_ncs_s1;
    assign w_ncs_rise  = ~r_ncs_s2 & r_ncs_s1;
    // r_armed blocks a frame already in flight when reset releases
    assign w_sample    = w_sclk_rise & ~r_ncs_s1 & ~r_ncs_s2 & r_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_buf   <= '0;
            r_armed <= 1'b0;
        end else if (w_ncs_fall) begin
            r_cnt   <= '0;
            r_buf   <= '0;
            r_armed <= 1'b1;
        end else if (w_sample) begin
            if (r_cnt < CW'(FL))
                r_buf <= {r_buf[FL-2:0], r_copi_s2};
            if (r_cnt < CW'(FL + 1))
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_rw      = r_buf[FL-1];
    assign w_addr    = r_buf[FL-2 -: 7];
    assign w_data    = r_buf[DATA_W-1:0];
    assign w_len_ok  = (r_cnt == CW'(FL));
    assign w_addr_ok = ({1'b0, w_addr} < NREGS8);
    assign w_accept  = w_len_ok & w_rw & w_addr_ok;
    assign w_bad     = ~w_len_ok | (w_rw & ~w_addr_ok);

    // Frame is judged on the SHIFT->CHECK edge so frame_err is high during CHECK
    // and the register/strobe update is visible during COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_regs      <= '0;
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
            r_ok        <= 1'b0;
            r_pend      <= 1'b0;
            r_wa        <= '0;
            r_wd        <= '0;
        end else begin
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ncs_fall)
                        r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_ncs_rise) begin
                        r_state     <= ST_CHECK;
                        r_frame_err <= w_bad;
                        r_ok        <= w_accept;
                        r_wa        <= w_addr;
                        r_wd        <= w_data;
                    end
                end
                ST_CHECK: begin
                    if (r_ok) begin
                        r_state <= ST_COMMIT;
                        r_pend  <= w_ncs_fall;
                        for (int unsigned k = 0; k < NUM_REGS; k++) begin
                            if (r_wa == 7'(k)) begin
                                r_regs[k*DATA_W +: DATA_W] <= r_wd;
                                r_wr_strobe[k]             <= 1'b1;
                            end
                        end
                    end else begin
                        r_state <= w_ncs_fall ? ST_SHIFT : ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    r_state <= (r_pend | w_ncs_fall) ? ST_SHIFT : ST_IDLE;
                    r_pend  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign regs_o    = r_regs;
    assign wr_strobe = r_wr_strobe;
    assign frame_err = r_frame_err;

`ifdef SPI_REGFILE_READBACK_EN
    localparam int SCW = $clog2(DATA_W + 1);

    logic              w_sclk_fall, w_rd_hit;
    logic [7:0]        w_next_byte;
    logic [DATA_W-1:0] w_rd_val;
    logic [DATA_W-1:0] r_sout;
    logic [SCW-1:0]    r_sout_cnt;
    logic              r_cipo;

    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
    // Header byte as it will look once the bit being sampled now is shifted in
    assign w_next_byte = {r_buf[6:0], r_copi_s2};
    assign w_rd_hit    = w_sample & (r_cnt == CW'(7)) & ~w_next_byte[7]
                       & ({1'b0, w_next_byte[6:0]} < NREGS8);

    always_comb begin
        w_rd_val = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++)
            if (w_next_byte[6:0] == 7'(k))
                w_rd_val = r_regs[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sout     <= '0;
            r_sout_cnt <= '0;
            r_cipo     <= 1'b0;
        end else if (r_ncs_s2) begin
            r_sout_cnt <= '0;
            r_cipo     <= 1'b0;
        end else if (w_rd_hit) begin
            r_sout     <= w_rd_val;
            r_sout_cnt <= SCW'(DATA_W);
        end else if (w_sclk_fall) begin
            if (r_sout_cnt != '0) begin
                r_cipo     <= r_sout[DATA_W-1];
                r_sout     <= r_sout << 1;
                r_sout_cnt <= r_sout_cnt - SCW'(1);
            end else begin
                r_cipo <= 1'b0;
            end
        end
    end

    assign cipo = r_cipo;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench for spi_regfile_peripheral: expected strobe/error pulses are queued
// by the stimulus and checked by an independent monitor.
module tb_spi_regfile_peripheral;

    localparam int NR   = 5;
    localparam int DW   = 8;
    localparam int HALF = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sclk = 1'b0;
    logic              copi = 1'b0;
    logic              ncs = 1'b1;
    logic              cipo;
    logic [NR*DW-1:0]  regs_o;
    logic [NR-1:0]     wr_strobe;
    logic              frame_err;

    spi_regfile_peripheral #(.NUM_REGS(NR), .DATA_W(DW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .copi      (copi),
        .ncs       (ncs),
        .cipo      (cipo),
        .regs_o    (regs_o),
        .wr_strobe (wr_strobe),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             err;
        logic [NR-1:0]    strobe;
        logic [NR*DW-1:0] regs;
    } exp_t;

    exp_t             q[$];
    exp_t             mon_e;
    logic [NR*DW-1:0] m_regs = '0;
    logic [31:0]      cap;
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (wr_strobe != '0 || frame_err)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got strobe=%b err=%b expected no pulse",
                         wr_strobe, frame_err);
            end else begin
                mon_e = q.pop_front();
                check("pulse_err", 64'(frame_err), 64'(mon_e.err));
                check("pulse_strobe", 64'(wr_strobe), 64'(mon_e.strobe));
                check("pulse_regs", 64'(regs_o), 64'(mon_e.regs));
            end
        end
    end

    task automatic push_write(input int a, input logic [DW-1:0] d);
        m_regs[a*DW +: DW] = d;
        q.push_back(exp_t'{err: 1'b0, strobe: NR'(1 << a), regs: m_regs});
    endtask

    task automatic push_err();
        q.push_back(exp_t'{err: 1'b1, strobe: '0, regs: m_regs});
    endtask

    // Shifts n bits MSB first; optionally pulses rst_n before bit rst_at.
    task automatic send(input logic [31:0] bits, input int n, input int gap, input int rst_at);
        cap = '0;
        ncs = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #25;
                check("rst_mid_regs", 64'(regs_o), 64'd0);
                check("rst_mid_cipo", 64'(cipo), 64'd0);
                m_regs = '0;
                rst_n = 1'b1;
            end
            copi = bits[n-1-i];
            #(HALF - 2);
            cap = {cap[30:0], cipo};
            #2 sclk = 1'b1;
            #HALF sclk = 1'b0;
        end
        #HALF ncs = 1'b1;
        copi = 1'b0;
        #50;
        check("latency_regs", 64'(regs_o), 64'(m_regs));
        #(gap - 50);
    endtask

    logic [15:0] exp_rb;

    initial begin
`ifdef SPI_REGFILE_READBACK_EN
        exp_rb = 16'h005A;
`else
        exp_rb = 16'h0000;
`endif
        #33;
        check("reset_regs", 64'(regs_o), 64'd0);
        check("reset_strobe", 64'(wr_strobe), 64'd0);
        check("reset_err", 64'(frame_err), 64'd0);
        check("reset_cipo", 64'(cipo), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        push_write(2, 8'hA5); send(32'h82A5, 16, 400, -1);
        check("write_cipo_quiet", 64'(cap[15:0]), 64'd0);
        check("reg2_a5", 64'(regs_o[23:16]), 64'hA5);
        push_err(); send(32'h8511, 16, 400, -1);
        push_err(); send(32'h81F, 12, 400, -1);
        push_err(); send(32'h8177A, 20, 400, -1);
        push_err(); send(32'hFF00, 16, 400, -1);
        push_write(3, 8'h5A); send(32'h835A, 16, 400, -1);
        send(32'h0300, 16, 400, -1);
        check("readback_cipo", 64'(cap[15:0]), 64'(exp_rb));
        push_err(); send(32'h030, 12, 400, -1);
        send(32'h0900, 16, 400, -1);
        send(32'h81FF, 16, 400, 9);
        check("after_rst_reg1", 64'(regs_o[15:8]), 64'h00);
        push_write(1, 8'h3C); send(32'h813C, 16, 400, -1);
        check("reg1_3c", 64'(regs_o[15:8]), 64'h3C);
        push_write(0, 8'h11); send(32'h8011, 16, 2 * HALF, -1);
        push_write(4, 8'h99); send(32'h8499, 16, 400, -1);

        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        check("final_regs", 64'(regs_o), 64'(m_regs));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
